// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared pipeline types for the memory-access stage: input and
//               output bundles, FSM state encoding, funct3 widths and the
//               natural-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   localparam int XLEN   = 64;
   localparam int F3_W   = 3;
   localparam int SIZE_W = 2;
   localparam int RD_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_HOLD    = 2'd3
   } lsu_state_t;

   typedef struct packed {
      logic            valid;
      logic            is_load;
      logic            is_store;
      logic [F3_W-1:0] funct3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [RD_W-1:0] rdaddr;
   } lsu_in_t;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rdaddr;
      logic [XLEN-1:0] data;
      logic            misalign;
   } lsu_out_t;

   // An access of 2**size bytes must have its low size address bits clear.
   function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                          input logic [2:0]        lsb);
      logic r;
      case (size)
         2'd0:    r = 1'b0;
         2'd1:    r = lsb[0];
         2'd2:    r = |lsb[1:0];
         default: r = |lsb;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_stage_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Combinational load-data extension. Raw dcache data is
//               right-justified; funct3[1:0] selects the width and funct3[2]
//               selects zero- instead of sign-extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] i_raw,
   input  logic [F3_W-1:0] i_funct3,
   output logic [XLEN-1:0] o_result
);

   // Select width and extension kind from funct3.
   always_comb begin
      o_result = i_raw;
      case (i_funct3)
         3'b000:  o_result = {{(XLEN-8){i_raw[7]}},   i_raw[7:0]};
         3'b001:  o_result = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
         3'b010:  o_result = {{(XLEN-32){i_raw[31]}}, i_raw[31:0]};
         3'b100:  o_result = {{(XLEN-8){1'b0}},       i_raw[7:0]};
         3'b101:  o_result = {{(XLEN-16){1'b0}},      i_raw[15:0]};
         3'b110:  o_result = {{(XLEN-32){1'b0}},      i_raw[31:0]};
         default: o_result = i_raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : Memory-access pipeline stage. Passes non-memory results
//               through, flags misaligned accesses, and turns aligned
//               loads/stores into single dcache requests whose result is
//               held (and buffered while write-back is stalled) until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage
   import lsu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   output logic            free,
   input  logic            in_valid,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic [4:0]      in_rdaddr,
   output logic            out_valid,
   output logic [4:0]      out_rdaddr,
   output logic [XLEN-1:0] out_data,
   output logic            out_misalign,
   output logic            dcache_r_rqst,
   output logic [XLEN-1:0] dcache_r_addr,
   output logic [2:0]      dcache_r_bits,
   input  logic            dcache_r_done,
   input  logic [XLEN-1:0] dcache_r_data,
   output logic            dcache_w_rqst,
   output logic [XLEN-1:0] dcache_w_addr,
   output logic [2:0]      dcache_w_bits,
   output logic [XLEN-1:0] dcache_w_data,
   input  logic            dcache_w_done
);

   lsu_in_t         w_in;
   lsu_state_t      r_state, w_state_nxt;
   lsu_out_t        r_out, w_out_nxt, r_buf, w_result;
   logic            w_out_we, w_buf_we, w_start, w_accept, w_done, w_mis;
   logic            r_rqst;
   logic [XLEN-1:0] r_addr, r_wdata, w_ext;
   logic [2:0]      r_bits;
   logic [4:0]      r_rdaddr;

   assign w_in = '{valid: in_valid, is_load: in_is_load, is_store: in_is_store,
                   funct3: in_funct3, addr: in_addr, wdata: in_wdata,
                   rdaddr: in_rdaddr};

   load_ext u_load_ext (
      .i_raw    (dcache_r_data),
      .i_funct3 (r_bits),
      .o_result (w_ext)
   );

   assign free     = (r_state == ST_IDLE);
   assign w_accept = ena & free & w_in.valid;
   assign w_mis    = is_misaligned(w_in.funct3[1:0], w_in.addr[2:0]);

   // Only the completion matching the outstanding request counts.
   assign w_done = ((r_state == ST_RD_WAIT) & dcache_r_done) |
                   ((r_state == ST_WR_WAIT) & dcache_w_done);

   // Completed access result: extended load data, or an all-zero store result.
   always_comb begin
      w_result       = '0;
      w_result.valid = 1'b1;
      if (r_state == ST_RD_WAIT) begin
         w_result.rdaddr = r_rdaddr;
         w_result.data   = w_ext;
      end
   end

   // Next-state and output-register update decisions.
   always_comb begin
      w_state_nxt = r_state;
      w_out_we    = 1'b0;
      w_out_nxt   = r_out;
      w_buf_we    = 1'b0;
      w_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ena) begin
               w_out_we        = 1'b1;
               w_out_nxt.valid = 1'b0;
            end
            if (w_accept) begin
               if (!w_in.is_load && !w_in.is_store) begin
                  w_out_nxt = '{valid: 1'b1, rdaddr: w_in.rdaddr,
                                data: w_in.addr, misalign: 1'b0};
               end else if (w_mis) begin
                  w_out_nxt = '{valid: 1'b1,
                                rdaddr: w_in.is_store ? 5'd0 : w_in.rdaddr,
                                data: '0, misalign: 1'b1};
               end else begin
                  w_start     = 1'b1;
                  w_state_nxt = w_in.is_load ? ST_RD_WAIT : ST_WR_WAIT;
               end
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (w_done && ena) begin
               w_out_we    = 1'b1;
               w_out_nxt   = w_result;
               w_state_nxt = ST_IDLE;
            end else if (w_done) begin
               w_buf_we    = 1'b1;
               w_state_nxt = ST_HOLD;
            end else if (ena) begin
               w_out_we        = 1'b1;
               w_out_nxt.valid = 1'b0;
            end
         end
         default: begin
            if (ena) begin
               w_out_we    = 1'b1;
               w_out_nxt   = r_buf;
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Request, output and hold-buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rqst   <= 1'b0;
         r_addr   <= '0;
         r_bits   <= '0;
         r_wdata  <= '0;
         r_rdaddr <= '0;
         r_out    <= '0;
         r_buf    <= '0;
      end else begin
         r_rqst <= w_start;
         if (w_start) begin
            r_addr   <= w_in.addr;
            r_bits   <= w_in.funct3;
            r_rdaddr <= w_in.rdaddr;
            if (w_in.is_store) r_wdata <= w_in.wdata;
         end
         if (w_out_we) r_out <= w_out_nxt;
         if (w_buf_we) r_buf <= w_result;
      end
   end

   assign out_valid     = r_out.valid;
   assign out_rdaddr    = r_out.rdaddr;
   assign out_data      = r_out.data;
   assign out_misalign  = r_out.misalign;

   assign dcache_r_rqst = r_rqst & (r_state == ST_RD_WAIT);
   assign dcache_r_addr = r_addr;
   assign dcache_r_bits = r_bits;
   assign dcache_w_rqst = r_rqst & (r_state == ST_WR_WAIT);
   assign dcache_w_addr = r_addr;
   assign dcache_w_bits = {1'b0, r_bits[1:0]};
   assign dcache_w_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_stage
// Description : Self-checking bench for lsu_stage: directed timing cases,
//               randomized traffic against a behavioural model, a dcache
//               responder and an output scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        free;
   logic        in_valid = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [63:0] in_addr = '0, in_wdata = '0;
   logic [4:0]  in_rdaddr = '0;
   logic        out_valid, out_misalign;
   logic [4:0]  out_rdaddr;
   logic [63:0] out_data;
   logic        dcache_r_rqst, dcache_w_rqst;
   logic [63:0] dcache_r_addr, dcache_w_addr, dcache_w_data;
   logic [2:0]  dcache_r_bits, dcache_w_bits;
   logic        dcache_r_done = 1'b0, dcache_w_done = 1'b0;
   logic [63:0] dcache_r_data = '0;

   int n_tests = 0;
   int n_fail  = 0;
   bit resp_en = 1'b1;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic        mis;
   } exp_t;

   typedef struct {
      logic        st;
      logic [63:0] addr;
      logic [2:0]  bits;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          k;
   } req_t;

   exp_t exp_q[$];
   req_t req_q[$];

   lsu_stage dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .free(free),
      .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_rdaddr(in_rdaddr),
      .out_valid(out_valid), .out_rdaddr(out_rdaddr), .out_data(out_data),
      .out_misalign(out_misalign),
      .dcache_r_rqst(dcache_r_rqst), .dcache_r_addr(dcache_r_addr),
      .dcache_r_bits(dcache_r_bits), .dcache_r_done(dcache_r_done),
      .dcache_r_data(dcache_r_data),
      .dcache_w_rqst(dcache_w_rqst), .dcache_w_addr(dcache_w_addr),
      .dcache_w_bits(dcache_w_bits), .dcache_w_data(dcache_w_data),
      .dcache_w_done(dcache_w_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   // Byte-count mask for an access of funct3[1:0].
   function automatic logic [63:0] size_mask(input logic [2:0] f3);
      int nb;
      nb = 1 << f3[1:0];
      return (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
   endfunction

   // Reference load extension from the arithmetic definition.
   function automatic logic [63:0] ref_ext(input logic [63:0] raw, input logic [2:0] f3);
      logic [63:0] m, v;
      int nb;
      nb = 1 << f3[1:0];
      m  = size_mask(f3);
      v  = raw & m;
      if (!f3[2] && raw[8 * nb - 1]) v = v | ~m;
      return v;
   endfunction

   // Record what one accepted instruction must produce.
   function automatic void push_instr(input logic ld, input logic st, input logic [2:0] f3,
                                      input logic [63:0] addr, input logic [63:0] wdata,
                                      input logic [4:0] rd, input logic [63:0] rdata,
                                      input int k);
      exp_t e;
      req_t r;
      int   nb;
      nb = 1 << f3[1:0];
      if (!ld && !st) begin
         e.rd = rd; e.data = addr; e.mis = 1'b0;
      end else if ((addr % 64'(nb)) != 0) begin
         e.rd = st ? 5'd0 : rd; e.data = '0; e.mis = 1'b1;
      end else begin
         r.st = st; r.addr = addr; r.bits = st ? {1'b0, f3[1:0]} : f3;
         r.wdata = wdata; r.rdata = rdata; r.k = k;
         req_q.push_back(r);
         e.rd = st ? 5'd0 : rd; e.data = st ? 64'd0 : ref_ext(rdata, f3); e.mis = 1'b0;
      end
      exp_q.push_back(e);
   endfunction

   // Output monitor: a result is taken on an edge where out_valid and ena are high.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && ena) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_rdaddr", out_rdaddr, e.rd);
               chk("out_misalign", out_misalign, e.mis);
               if (!e.mis) chk("out_data", out_data, e.data);
            end
         end
      end
   end

   // Dcache responder: checks each request, then completes it after k cycles,
   // toggling the wrong completion channel meanwhile.
   initial begin
      req_t        rq;
      logic [63:0] m, a;
      forever begin
         @(negedge clk);
         if (resp_en && (dcache_r_rqst || dcache_w_rqst)) begin
            if (req_q.size() == 0) begin
               chk("unexpected_rqst", 64'd1, 64'd0);
            end else begin
               rq = req_q.pop_front();
               m  = size_mask(rq.bits);
               a  = rq.st ? dcache_w_addr : dcache_r_addr;
               chk("rqst_kind", dcache_w_rqst, rq.st);
               chk("rqst_addr", a, rq.addr);
               chk("rqst_bits", rq.st ? dcache_w_bits : dcache_r_bits, rq.bits);
               if (rq.st) chk("w_data", dcache_w_data & m, rq.wdata & m);
               for (int c = 0; c < rq.k; c++) begin
                  if (rq.st) dcache_r_done = 1'($urandom_range(0, 1));
                  else       dcache_w_done = 1'($urandom_range(0, 1));
                  dcache_r_data = {$urandom, $urandom};
                  @(negedge clk);
                  chk("rqst_single_pulse", dcache_r_rqst | dcache_w_rqst, 64'd0);
                  chk("rqst_addr_stable", rq.st ? dcache_w_addr : dcache_r_addr, rq.addr);
                  if (rq.st) chk("w_data_stable", dcache_w_data & m, rq.wdata & m);
                  chk("no_valid_while_wait", out_valid, 64'd0);
               end
               dcache_r_done = !rq.st;
               dcache_w_done = rq.st;
               dcache_r_data = rq.rdata;
               @(posedge clk);
               #1;
               dcache_r_done = 1'b0;
               dcache_w_done = 1'b0;
            end
         end
      end
   end

   // Directed issue with ena held high; measures edges from capture to out_valid.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [4:0] rd, input logic [63:0] rdata,
                        input int k, input int exp_lat, input string nm);
      int lat;
      ena = 1'b1;
      in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
      in_addr = addr; in_wdata = wdata; in_rdaddr = rd;
      chk({nm, "_free_at_issue"}, free, 64'd1);
      push_instr(ld, st, f3, addr, wdata, rd, rdata, k);
      lat = 0;
      for (int c = 1; c <= 50 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (out_valid) lat = c;
         else chk({nm, "_busy"}, free, 64'd0);
      end
      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({nm, "_free_after"}, free, 64'd1);
   endtask

   initial begin
      logic       ld, st, acc;
      logic [2:0] f3;
      logic [63:0] a;
      int cls;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_rdaddr", out_rdaddr, 64'd0);
      chk("rst_out_misalign", out_misalign, 64'd0);
      chk("rst_rqst", {dcache_r_rqst, dcache_w_rqst}, 64'd0);
      chk("rst_addr", dcache_r_addr | dcache_w_addr | dcache_w_data, 64'd0);
      chk("rst_free", free, 64'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b0, 1'b0, 3'b000, 64'h0000_0001_2345_6789, '0, 5'd4, '0, 0, 1, "alu0");
      issue(1'b0, 1'b0, 3'b101, 64'hFEDC_BA98_7654_3210, '0, 5'd6, '0, 0, 1, "alu1");
      issue(1'b1, 1'b0, 3'b000, 64'h1003, '0, 5'd5, 64'h80, 0, 2, "lb");
      issue(1'b1, 1'b0, 3'b110, 64'h2004, '0, 5'd8, 64'hDEAD_BEEF_8000_0000, 3, 5, "lwu");
      issue(1'b0, 1'b1, 3'b011, 64'h3000, 64'h1122_3344_5566_7788, 5'd7, '0, 2, 4, "sd");
      issue(1'b1, 1'b0, 3'b010, 64'h1002, '0, 5'd9, '0, 0, 1, "lw_mis");
      issue(1'b1, 1'b0, 3'b011, 64'h4008, '0, 5'd10, 64'h8765_4321_0FED_CBA9, 1, 3, "ld_b2b");
      issue(1'b1, 1'b0, 3'b001, 64'h4010, '0, 5'd0, 64'h0000_0000_0000_8001, 0, 2, "lh_x0");

      // Completion while write-back is stalled goes through the hold buffer.
      in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b101;
      in_addr = 64'h5002; in_rdaddr = 5'd11;
      push_instr(1'b1, 1'b0, 3'b101, 64'h5002, '0, 5'd11, 64'h0000_0000_0000_F00D, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ena = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_wait_valid", out_valid, 64'd0);
      @(posedge clk);
      #1;
      chk("hold_valid0", out_valid, 64'd0);
      chk("hold_busy0", free, 64'd0);
      @(posedge clk);
      #1;
      chk("hold_valid1", out_valid, 64'd0);
      chk("hold_busy1", free, 64'd0);
      ena = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_release_valid", out_valid, 64'd1);
      chk("hold_release_free", free, 64'd1);

      // Randomized traffic with random write-back stalls.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            ena = ($urandom_range(0, 3) != 0);
         end
         cls = $urandom_range(0, 2);
         ld  = (cls == 1);
         st  = (cls == 2);
         f3  = ld ? 3'($urandom_range(0, 6)) : st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         a   = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
         in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
         in_addr = a; in_wdata = {$urandom, $urandom}; in_rdaddr = 5'($urandom_range(0, 31));
         acc = 1'b0;
         for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            if (ena && free) begin
               acc = 1'b1;
               push_instr(ld, st, f3, in_addr, in_wdata, in_rdaddr,
                          {$urandom, $urandom}, $urandom_range(0, 4));
            end
            @(posedge clk);
            #1;
            ena = ($urandom_range(0, 3) != 0);
         end
         if (!acc) chk("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end
      ena = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
      #1;
      chk("drain_exp_q", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a read; a late completion must be ignored.
      issue(1'b0, 1'b0, 3'b000, 64'hA5A5_0000_1234_5678, '0, 5'd12, '0, 0, 1, "alu_pre_rst");
      resp_en = 1'b0;
      in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b011;
      in_addr = 64'h6000; in_rdaddr = 5'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("rst_mid_rqst", dcache_r_rqst, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_free", free, 64'd1);
      chk("rst_mid_valid", out_valid, 64'd0);
      chk("rst_mid_data", out_data, 64'd0);
      chk("rst_mid_rqst_drop", dcache_r_rqst, 64'd0);
      chk("rst_mid_addr", dcache_r_addr, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dcache_r_done = 1'b1;
      dcache_r_data = 64'h1234;
      @(posedge clk);
      #1;
      chk("late_done_valid", out_valid, 64'd0);
      @(posedge clk);
      #1;
      dcache_r_done = 1'b0;
      chk("late_done_valid2", out_valid, 64'd0);
      chk("late_done_free", free, 64'd1);
      chk("end_exp_q", 64'(exp_q.size()), 64'd0);
      chk("end_req_q", 64'(req_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
